// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   RV32I load/store stage between the execute stage and the memory controller.
//   It accepts one request at a time and turns byte, half and word accesses into
//   word-aligned memory transactions with byte enables. When the memory acks, it
//   returns load data that is sign- or zero-extended. A watchdog ends a memory
//   access that never completes and reports it as an error response.
//
//   Optional feature: define LSU_MISALIGN_TRAP_EN to reject misaligned half and
//   word accesses with an error. When it is undefined, the offending low address
//   bits are ignored and the access goes ahead.
//
// Parameters
//   ADDR_W    byte-address width of req_addr / mem_addr
//   TIMEOUT   maximum number of WAIT cycles before an error response (0 = off)
//
// Ports
//   clk, rst                     clock; synchronous active-high reset
//   req_valid/req_ready          request handshake (ready only while idle)
//   req_we/req_funct3            store flag and RISC-V funct3
//   req_addr/req_wdata           byte address and right-aligned store data
//   rsp_valid/rsp_rdata/rsp_err  one-cycle response pulse, data and error
//   mem_req/mem_we/mem_addr      memory request, write flag, word address
//   mem_be/mem_wdata             byte enables and lane-replicated store data
//   mem_ack/mem_rdata            memory completion and read word
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        ld_f3_q, ld_f3_d;
  logic [1:0]        ld_off_q, ld_off_d;

  logic              req_ready_d;
  logic              rsp_valid_d;
  logic [31:0]       rsp_rdata_d;
  logic              rsp_err_d;
  logic              mem_req_d;
  logic              mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [3:0]        mem_be_d;
  logic [31:0]       mem_wdata_d;

  logic              illegal_c;
  logic              misalign_c;
  logic              reject_c;
  logic [3:0]        lane_be_c;
  logic [1:0]        lane_off_c;
  logic [31:0]       lane_wdata_c;
  logic [7:0]        ld_byte_c;
  logic [15:0]       ld_half_c;
  logic [31:0]       ld_ext_c;
  logic              timeout_c;

  // Request decode: byte lanes, replicated store data and illegal encodings.
  always_comb begin
    illegal_c    = 1'b0;
    lane_be_c    = 4'b0000;
    lane_off_c   = 2'b00;
    lane_wdata_c = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        lane_off_c   = req_addr[1:0];
        lane_be_c    = 4'b0001 << req_addr[1:0];
        lane_wdata_c = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        lane_off_c   = {req_addr[1], 1'b0};
        lane_be_c    = 4'b0011 << {req_addr[1], 1'b0};
        lane_wdata_c = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        lane_be_c = 4'b1111;
      end
      default: begin
        illegal_c = 1'b1;
      end
    endcase
    // 110 is never legal; unsigned variants (funct3[2]) exist only for loads.
    if (req_funct3[2] && (req_funct3[1] || req_we)) begin
      illegal_c = 1'b1;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // Misaligned half/word accesses are trapped instead of being silently aligned.
  always_comb begin
    misalign_c = 1'b0;
    if (req_funct3[1:0] == 2'b01) begin
      misalign_c = req_addr[0];
    end else if (req_funct3[1:0] == 2'b10) begin
      misalign_c = |req_addr[1:0];
    end
  end
`else
  assign misalign_c = 1'b0;
`endif

  assign reject_c = illegal_c | misalign_c;

  // Load data extraction and extension from the acked memory word.
  always_comb begin
    ld_byte_c = mem_rdata[{ld_off_q, 3'b000} +: 8];
    ld_half_c = ld_off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (ld_f3_q)
      3'b000:  ld_ext_c = {{24{ld_byte_c[7]}}, ld_byte_c};
      3'b001:  ld_ext_c = {{16{ld_half_c[15]}}, ld_half_c};
      3'b100:  ld_ext_c = {24'h000000, ld_byte_c};
      3'b101:  ld_ext_c = {16'h0000, ld_half_c};
      default: ld_ext_c = mem_rdata;
    endcase
  end

  // The watchdog fires on the TIMEOUT-th WAIT cycle without an ack.
  assign timeout_c = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ld_f3_d     = ld_f3_q;
    ld_off_d    = ld_off_q;
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'h0000_0000;
    rsp_err_d   = 1'b0;
    mem_req_d   = 1'b0;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_be_d    = mem_be;
    mem_wdata_d = mem_wdata;

    case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready) begin
          req_ready_d = 1'b0;
          if (reject_c) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d     = S_WAIT;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            mem_be_d    = lane_be_c;
            mem_wdata_d = lane_wdata_c;
            ld_f3_d     = req_funct3;
            ld_off_d    = lane_off_c;
          end
        end
      end

      S_WAIT: begin
        if (mem_ack) begin
          // An ack in the timeout cycle still completes the access normally.
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = mem_we ? 32'h0000_0000 : ld_ext_c;
        end else if (timeout_c) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          mem_req_d = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end

      S_RESP: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end

      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ld_f3_q   <= 3'b000;
      ld_off_q  <= 2'b00;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0000_0000;
      rsp_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'b0000;
      mem_wdata <= 32'h0000_0000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ld_f3_q   <= ld_f3_d;
      ld_off_q  <= ld_off_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_be    <= mem_be_d;
      mem_wdata <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//   Self-checking bench for load_store_unit. For each request, a transaction-
//   level model predicts the word address, byte enables, store data, load
//   result, error flag and the number of cycles mem_req stays high. Cycle k
//   counts from the accepting edge. One compare process checks the outputs
//   against that timeline at every falling edge.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

  localparam int unsigned TO = 15;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic        err;
    int          len;   // cycles with mem_req high; response follows in len+1
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   k = 1000;
  int   cur_len = 0;
  bit   chk_en = 1'b0;
  exp_t ex;

  load_store_unit #(.ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Transaction-level model from the access rules; ack_cyc = 0 means never acked.
  function automatic exp_t model(logic we, logic [2:0] f3, logic [31:0] addr,
                                 logic [31:0] wd, logic [31:0] rd, int ack_cyc);
    exp_t   e;
    int     size, nb, off;
    logic   illegal, mis, reject;
    longint v, mask, mult;
    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2]);
    size    = int'(f3[1:0]);
    if (size == 3) size = 2;
    nb      = 1 << size;
    mis     = (nb == 2 && addr[0]) || (nb == 4 && addr[1:0] != 2'b00);
`ifdef LSU_MISALIGN_TRAP_EN
    reject  = illegal || mis;
`else
    reject  = illegal;
`endif
    // Natural alignment of the access: offset rounded down to a multiple of nb.
    off     = (int'(addr[1:0]) / nb) * nb;
    mask    = (longint'(1) << (8 * nb)) - 1;
    mult    = (nb == 1) ? 64'h0101_0101 : (nb == 2) ? 64'h0001_0001 : 64'h1;
    e.addr  = addr & 32'hFFFF_FFFC;
    e.we    = we;
    e.be    = 4'(((1 << nb) - 1) << off);
    e.wdata = 32'((longint'(wd) & mask) * mult);
    v = (longint'(rd) >> (8 * off)) & mask;
    if (!f3[2] && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
      v = v - (longint'(1) << (8 * nb));
    if (reject) begin
      e.len = 0; e.err = 1'b1; e.rdata = 32'h0;
    end else if (ack_cyc >= 1 && ack_cyc <= int'(TO)) begin
      e.len = ack_cyc; e.err = 1'b0; e.rdata = we ? 32'h0 : 32'(v);
    end else begin
      e.len = int'(TO); e.err = 1'b1; e.rdata = 32'h0;
    end
    return e;
  endfunction

  // Compare process: output timeline relative to the accepting edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 32'(req_ready), 32'(k >= cur_len + 2));
      chk("mem_req",   32'(mem_req),   32'(k >= 1 && k <= cur_len));
      chk("rsp_valid", 32'(rsp_valid), 32'(k == cur_len + 1));
      if (k >= 1 && k <= cur_len) begin
        chk("mem_addr",  mem_addr,         ex.addr);
        chk("mem_be",    32'(mem_be),      32'(ex.be));
        chk("mem_we",    32'(mem_we),      32'(ex.we));
        if (ex.we) chk("mem_wdata", mem_wdata, ex.wdata);
      end
      if (k == cur_len + 1) begin
        chk("rsp_rdata", rsp_rdata,        ex.rdata);
        chk("rsp_err",   32'(rsp_err),     32'(ex.err));
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
    k++;
  endtask

  // Issue one request, then act as memory; rst_at > 0 resets in that cycle.
  task automatic run_txn(logic we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wd,
                         logic [31:0] rd, int ack, int rst_at);
    exp_t e;
    e = model(we, f3, addr, wd, rd, ack);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    ex = e; cur_len = e.len; k = 1;
    while (k <= e.len + 1) begin
      @(negedge clk);
      if (rst_at != 0 && k == rst_at) begin
        rst = 1'b1; mem_ack = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; k = 1000; cur_len = 0;
        return;
      end
      if (ack != 0 && k == ack) mem_ack = 1'b1;
      else if (k == e.len + 1) mem_ack = 1'($urandom);
      else mem_ack = 1'b0;
      mem_rdata = (k == ack) ? rd : $urandom;
      @(posedge clk); #1;
      k++;
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    exp_t        e;
    logic        we;
    logic [2:0]  f3;
    int          r, ack;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    ex = model(1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 0);

    // Model anchors computed by hand.
    e = model(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1);
    chk("pin_sw_addr", e.addr, 32'h0000_0100);
    chk("pin_sw_be", 32'(e.be), 32'hF);
    chk("pin_sw_wdata", e.wdata, 32'hDEADBEEF);
    chk("pin_sw_len", 32'(e.len), 32'd1);
    e = model(1'b0, 3'b000, 32'h203, 32'h0, 32'h80FF_0000, 1);
    chk("pin_lb_be", 32'(e.be), 32'h8);
    chk("pin_lb_rdata", e.rdata, 32'hFFFF_FF80);
    e = model(1'b0, 3'b100, 32'h203, 32'h0, 32'h80FF_0000, 1);
    chk("pin_lbu_rdata", e.rdata, 32'h0000_0080);
    e = model(1'b1, 3'b001, 32'h12, 32'h0000_A5C3, 32'h0, 1);
    chk("pin_sh_be", 32'(e.be), 32'hC);
    chk("pin_sh_wdata", e.wdata, 32'hA5C3_A5C3);
    e = model(1'b0, 3'b101, 32'h12, 32'h0, 32'h1234_5678, 1);
    chk("pin_lhu_rdata", e.rdata, 32'h0000_1234);
    e = model(1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 0);
    chk("pin_to_len", 32'(e.len), 32'd15);
    chk("pin_to_err", 32'(e.err), 32'd1);
    e = model(1'b0, 3'b010, 32'h40, 32'h0, 32'h5, 15);
    chk("pin_ack15_err", 32'(e.err), 32'd0);
    e = model(1'b0, 3'b011, 32'h40, 32'h0, 32'h0, 1);
    chk("pin_f3_011_err", 32'(e.err), 32'd1);
    e = model(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 1);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("pin_lw_mis_err", 32'(e.err), 32'd1);
    chk("pin_lw_mis_len", 32'(e.len), 32'd0);
`else
    chk("pin_lw_mis_addr", e.addr, 32'h0000_0100);
    chk("pin_lw_mis_be", 32'(e.be), 32'hF);
    chk("pin_lw_mis_err", 32'(e.err), 32'd0);
`endif

    // Reset, then check every output against its reset value.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; k = 1000; cur_len = 0; chk_en = 1'b1;
    @(negedge clk);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_be", 32'(mem_be), 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);

    // Directed cases.
    run_txn(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1, 0);
    run_txn(1'b0, 3'b000, 32'h203, 32'h0, 32'h80FF_0000, 1, 0);
    run_txn(1'b0, 3'b100, 32'h203, 32'h0, 32'h80FF_0000, 2, 0);
    run_txn(1'b1, 3'b001, 32'h12, 32'h0000_A5C3, 32'h0, 3, 0);
    run_txn(1'b0, 3'b101, 32'h12, 32'h0, 32'h1234_5678, 1, 0);
    run_txn(1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 0, 0);
    run_txn(1'b0, 3'b010, 32'h400, 32'h0, 32'hCAFE_F00D, 15, 0);
    run_txn(1'b0, 3'b010, 32'h101, 32'h0, 32'h1111_2222, 1, 0);
    run_txn(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1, 0);
    run_txn(1'b1, 3'b100, 32'h100, 32'h55, 32'h0, 1, 0);
    run_txn(1'b0, 3'b010, 32'h800, 32'h0, 32'h0, 0, 5);
    step();
    run_txn(1'b0, 3'b001, 32'h802, 32'h0, 32'h8001_7FFF, 2, 0);

    // Randomized requests, mostly legal, with varied ack timing.
    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom);
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom);
      else if (we) f3 = 3'($urandom_range(0, 2));
      else begin
        r  = $urandom_range(0, 4);
        f3 = (r < 3) ? 3'(r) : 3'(r + 1);
      end
      r = $urandom_range(0, 7);
      if (r == 0) ack = 0;
      else if (r == 1) ack = $urandom_range(14, 16);
      else ack = $urandom_range(1, 4);
      run_txn(we, f3, $urandom, $urandom, $urandom, ack,
              ($urandom_range(0, 19) == 0) ? 1 : 0);
      repeat ($urandom_range(0, 2)) step();
    end
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
